// File: rtl/vector_frame_sequencer_pkg.sv
// Shared types for the vector frame sequencer: the vector-list entry layout
// and the scheduler state encoding.
package vector_pkg;

  // Width of each beam coordinate as stored in the vector list.
  localparam int DAC_WIDTH = 8;

  // One vector-list entry: {y, x, draw, pos}.
  typedef struct packed {
    logic [DAC_WIDTH-1:0] y;
    logic [DAC_WIDTH-1:0] x;
    logic                 draw;
    logic                 pos;
  } vec_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNDARY,
    ST_FETCH,
    ST_OFFER,
    ST_WAIT
  } seq_state_t;

endpackage

// File: rtl/vector_frame_sequencer_frame_timer.sv
// Saturating frame-period counter. The clear cycle (the frame boundary)
// counts as cycle 0, so the count reads k exactly k cycles after the
// boundary and 'elapsed' rises LIMIT-1 cycles after it.
module frame_timer #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic elapsed
);

  localparam int              CW   = $clog2(LIMIT);
  localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  logic [CW-1:0] count;

  // Count cycles since the last boundary, holding at LIMIT-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= ONE;
    end else if (count != LAST) begin
      count <= count + ONE;
    end
  end

  assign elapsed = (count == LAST);

endmodule

// File: rtl/vector_frame_sequencer.sv
// Double-buffered vector-list scheduler. Walks the front bank of the vector
// RAM one entry per handshake, enforces a minimum frame period and swaps
// banks only at frame boundaries when the scene writer has asked for it.
module vector_frame_sequencer
  import vector_pkg::*;
#(
  parameter int ADDR_WIDTH       = 8,
  parameter int DATA_WIDTH       = 18,
  parameter int FRAME_MIN_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  swap_req,
  input  logic [ADDR_WIDTH:0]   swap_len,
  output logic                  swap_ack,
  output logic [ADDR_WIDTH:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic [DATA_WIDTH-1:0] vec_data,
  output logic                  front_bank,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

  seq_state_t            state;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   pend_len;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH:0]   frame_len;
  logic                  last_entry;
  logic                  period_elapsed;

  // A bank can never hold more than DEPTH entries.
  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] n);
    return (n > DEPTH_LEN) ? DEPTH_LEN : n;
  endfunction

  // Length of the frame about to start, taking a pending swap into account.
  assign frame_len  = pending ? pend_len : len;
  assign last_entry = ({1'b0, idx} == (len - LEN_ONE));
  assign rd_addr    = {front_bank, idx};

  frame_timer #(
    .LIMIT (FRAME_MIN_CYCLES)
  ) u_frame_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_BOUNDARY),
    .elapsed (period_elapsed)
  );

  // Scheduler FSM with all outputs registered.
  // NOTE: every register here is assigned with <=, so all branches see the
  // pre-edge values of state, idx and pending regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      front_bank  <= 1'b0;
      len         <= '0;
      pend_len    <= '0;
      pending     <= 1'b0;
      idx         <= '0;
      vec_valid   <= 1'b0;
      vec_data    <= '0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      swap_ack    <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (enable) state <= ST_BOUNDARY;
        end

        ST_BOUNDARY: begin
          frame_start <= 1'b1;
          if (pending) begin
            front_bank <= ~front_bank;
            len        <= pend_len;
            swap_ack   <= 1'b1;
            pending    <= 1'b0;
          end
          if (frame_len != '0) begin
            state <= ST_FETCH;
            busy  <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_FETCH: begin
          vec_data  <= rd_data;
          vec_valid <= 1'b1;
          state     <= ST_OFFER;
        end

        ST_OFFER: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            if (last_entry) begin
              idx        <= '0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_WAIT;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= ST_FETCH;
            end
          end
        end

        ST_WAIT: begin
          if (period_elapsed) state <= enable ? ST_BOUNDARY : ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

      // A request arriving in the boundary cycle itself overrides the clear
      // above and is held for the following boundary; later requests win.
      if (swap_req) begin
        pending  <= 1'b1;
        pend_len <= clamp_len(swap_len);
      end
    end
  end

endmodule

// File: tb/tb_vector_frame_sequencer.sv
// Directed bench for vector_frame_sequencer with a small combinational RAM
// model whose contents are a known function of the address.
module tb_vector_frame_sequencer;
  import vector_pkg::*;

  localparam int AW  = 4;
  localparam int DW  = 18;
  localparam int FMC = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          swap_req = 1'b0;
  logic [AW:0]   swap_len = '0;
  logic          swap_ack;
  logic [AW:0]   rd_addr;
  logic [DW-1:0] rd_data;
  logic          vec_valid;
  logic          vec_ready = 1'b0;
  logic [DW-1:0] vec_data;
  logic          front_bank;
  logic          frame_start;
  logic          frame_done;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  int cyc      = 0;
  int fd_count = 0;
  int vv_count = 0;
  int fs_times[$];
  int sa_times[$];
  logic [DW-1:0] got[$];

  vector_frame_sequencer #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .FRAME_MIN_CYCLES (FMC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .swap_req    (swap_req),
    .swap_len    (swap_len),
    .swap_ack    (swap_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .vec_data    (vec_data),
    .front_bank  (front_bank),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Known RAM contents: distinct entry per address.
  function automatic logic [DW-1:0] entry_of(input logic [AW:0] a);
    vec_entry_t e;
    e.y    = 8'(a) * 8'd3 + 8'd1;
    e.x    = 8'(a) ^ 8'h5A;
    e.draw = a[0];
    e.pos  = a[1];
    return e;
  endfunction

  assign rd_data = entry_of(rd_addr);

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_start) fs_times.push_back(cyc);
    if (swap_ack) sa_times.push_back(cyc);
    if (frame_done) fd_count <= fd_count + 1;
    if (vec_valid) vv_count <= vv_count + 1;
    if (vec_valid && vec_ready) got.push_back(vec_data);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_swap(input logic [AW:0] n);
    swap_req = 1'b1;
    swap_len = n;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int base = fs_times.size();
    for (int i = 0; i < budget && fs_times.size() == base; i++) tick();
    check(tag, 32'(fs_times.size() > base), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base = fd_count;
    for (int i = 0; i < budget && fd_count == base; i++) tick();
    check(tag, 32'(fd_count > base), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !vec_valid; i++) tick();
    check(tag, 32'(vec_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(vec_valid), 32'd0);
    check({tag, "_data"}, 32'(vec_data), 32'd0);
    check({tag, "_bank"}, 32'(front_bank), 32'd0);
    check({tag, "_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pulses"}, 32'({frame_start, frame_done, swap_ack}), 32'd0);
  endtask

  initial begin
    int gbase, sabase, fsbase, vvbase, fdbase;

    // Reset state.
    tick(3);
    check_all_zero("reset");

    // 1) First boundary swaps in a 3-entry bank 1 and emits it in order.
    rst = 1'b1;
    enable = 1'b1;
    vec_ready = 1'b1;
    gbase = got.size();
    pulse_swap(5'd3);
    wait_done("t1_done", 40);
    check("t1_count", 32'(got.size() - gbase), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t1_entry%0d", i), 32'(got[gbase+i]), 32'(entry_of(5'(16 + i))));
    check("t1_bank", 32'(front_bank), 32'd1);
    check("t1_acks", 32'(sa_times.size()), 32'd1);
    check("t1_ack_at_start", 32'(sa_times[0]), 32'(fs_times[0]));
    tick(5);
    check("t1_done_once", 32'(fd_count), 32'd1);

    // 3) Swap to len 2; frame starts are exactly FMC cycles apart.
    pulse_swap(5'd2);
    fsbase = fs_times.size();
    wait_start("t3_start0", 100);
    check("t3_bank", 32'(front_bank), 32'd0);
    wait_start("t3_start1", 100);
    wait_start("t3_start2", 100);
    check("t3_gap0", 32'(fs_times[fsbase] - fs_times[fsbase-1]), 32'(FMC));
    check("t3_gap1", 32'(fs_times[fsbase+1] - fs_times[fsbase]), 32'(FMC));
    check("t3_gap2", 32'(fs_times[fsbase+2] - fs_times[fsbase+1]), 32'(FMC));
    gbase = got.size();
    wait_done("t3_done", 40);
    check("t3_count", 32'(got.size() - gbase), 32'd2);
    check("t3_last", 32'(got[got.size()-1]), 32'(entry_of(5'd1)));

    // 2) Consumer stalls 10 cycles: offered entry holds steady.
    vec_ready = 1'b0;
    wait_start("t2_start", 100);
    wait_valid("t2_valid", 10);
    for (int i = 0; i < 10; i++) begin
      check("t2_hold_valid", 32'(vec_valid), 32'd1);
      check("t2_hold_data", 32'(vec_data), 32'(entry_of(5'd0)));
      tick();
    end
    vec_ready = 1'b1;
    gbase = got.size();
    tick();
    check("t2_drop", 32'(vec_valid), 32'd0);
    check("t2_accepted", 32'(got.size() - gbase), 32'd1);
    check("t2_accepted_data", 32'(got[gbase]), 32'(entry_of(5'd0)));
    wait_done("t2_done", 40);

    // 4) Two requests in one frame: latest length wins, one ack.
    pulse_swap(5'd4);
    tick(2);
    pulse_swap(5'd6);
    sabase = sa_times.size();
    gbase = got.size();
    wait_start("t4_start", 100);
    wait_done("t4_done", 40);
    check("t4_count", 32'(got.size() - gbase), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_entry%0d", i), 32'(got[gbase+i]), 32'(entry_of(5'(16 + i))));
    check("t4_bank", 32'(front_bank), 32'd1);
    wait_start("t4_next_start", 100);
    wait_done("t4_next_done", 40);
    check("t4_single_ack", 32'(sa_times.size() - sabase), 32'd1);

    // Oversized length clamps to the bank depth.
    pulse_swap(5'd20);
    gbase = got.size();
    wait_start("clamp_start", 100);
    wait_done("clamp_done", 60);
    check("clamp_count", 32'(got.size() - gbase), 32'd16);
    check("clamp_first", 32'(got[gbase]), 32'(entry_of(5'd0)));
    check("clamp_last", 32'(got[gbase+15]), 32'(entry_of(5'd15)));

    // 5) Blank bank: frames keep starting, nothing is offered.
    pulse_swap(5'd0);
    wait_start("t5_swap_start", 100);
    check("t5_bank", 32'(front_bank), 32'd1);
    vvbase = vv_count;
    fdbase = fd_count;
    fsbase = fs_times.size();
    wait_start("t5_start1", 100);
    wait_start("t5_start2", 100);
    check("t5_gap", 32'(fs_times[fsbase+1] - fs_times[fsbase]), 32'(FMC));
    check("t5_no_valid", 32'(vv_count - vvbase), 32'd0);
    check("t5_no_done", 32'(fd_count - fdbase), 32'd0);

    // 6b) enable dropped mid-frame: frame completes, then the sequencer idles.
    pulse_swap(5'd3);
    gbase = got.size();
    wait_start("t6_start", 100);
    enable = 1'b0;
    wait_done("t6_done", 40);
    check("t6_count", 32'(got.size() - gbase), 32'd3);
    check("t6_last", 32'(got[gbase+2]), 32'(entry_of(5'd2)));
    fsbase = fs_times.size();
    tick(80);
    check("t6_no_new_frame", 32'(fs_times.size() - fsbase), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    sabase = sa_times.size();
    pulse_swap(5'd5);
    tick(10);
    check("t6_no_idle_swap", 32'(sa_times.size() - sabase), 32'd0);
    check("t6_idle_bank", 32'(front_bank), 32'd0);

    // 6a) Reset while an entry is being offered.
    enable = 1'b1;
    vec_ready = 1'b0;
    wait_start("t6r_start", 20);
    check("t6r_bank", 32'(front_bank), 32'd1);
    wait_valid("t6r_valid", 10);
    rst = 1'b0;
    tick();
    check_all_zero("t6r_reset");
    rst = 1'b1;
    enable = 1'b0;
    tick(5);
    check("t6r_stay_idle", 32'({vec_valid, busy}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
